button_events: RTL and testbench

//  Consumes the 5 debounced button levels from debounce_wrapper (results[4:0]) and turns them

---
 rtl/button_events.sv | 117 +++++++++++
 tb/tb_button_events.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/button_events.sv
// Per-button press/release/click/long-press/auto-repeat pulse generator.
// "release" and "repeat" are language keywords, so those outputs carry an _evt suffix.
module button_events #(
    parameter int unsigned N_BTN         = 5,
    parameter int unsigned LONG_CYCLES   = 12500000,
    parameter int unsigned REPEAT_CYCLES = 2500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] buttons_db,
    output logic [N_BTN-1:0] held,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_evt,
    output logic [N_BTN-1:0] click,
    output logic [N_BTN-1:0] long_press,
    output logic [N_BTN-1:0] repeat_evt
);

    localparam int unsigned MAX_CYCLES =
        (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StShort, StLong} state_t;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             held_q;
        logic             press_q, press_d;
        logic             rel_q, rel_d;
        logic             click_q, click_d;
        logic             long_q, long_d;
        logic             rpt_q, rpt_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            click_d = 1'b0;
            long_d  = 1'b0;
            rpt_d   = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (buttons_db[i]) begin
                        state_d = StShort;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end
                end
                StShort: begin
                    // Release wins over a coincident long-press threshold.
                    if (!buttons_db[i]) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        rel_d   = 1'b1;
                        click_d = 1'b1;
                    end else if (cnt_q == LONG_LAST) begin
                        state_d = StLong;
                        cnt_d   = '0;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StLong: begin
                    if (!buttons_db[i]) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        rel_d   = 1'b1;
                    end else if (cnt_q == REP_LAST) begin
                        cnt_d = '0;
                        rpt_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                held_q  <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                click_q <= 1'b0;
                long_q  <= 1'b0;
                rpt_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                held_q  <= (state_d != StIdle);
                press_q <= press_d;
                rel_q   <= rel_d;
                click_q <= click_d;
                long_q  <= long_d;
                rpt_q   <= rpt_d;
            end
        end

        assign held[i]        = held_q;
        assign press[i]       = press_q;
        assign release_evt[i] = rel_q;
        assign click[i]       = click_q;
        assign long_press[i]  = long_q;
        assign repeat_evt[i]  = rpt_q;
    end

endmodule

// File: tb/tb_button_events.sv
// Bench for button_events: directed scenarios plus random toggling, checked against a
// hold-time reference model through an expected-response queue.
module tb_button_events;

    localparam int N   = 5;
    localparam int L   = 8;
    localparam int R   = 4;

    typedef struct packed {
        logic [N-1:0] held;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] click;
        logic [N-1:0] lp;
        logic [N-1:0] rpt;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] buttons_db = '0;
    logic [N-1:0] held, press, release_evt, click, long_press, repeat_evt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    obs_t exp_q[$];

    // Reference model state: whether a press is in progress and edges since the press edge.
    bit pressed[N];
    int t_since[N];

    button_events #(
        .N_BTN        (N),
        .LONG_CYCLES  (L),
        .REPEAT_CYCLES(R)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .buttons_db (buttons_db),
        .held       (held),
        .press      (press),
        .release_evt(release_evt),
        .click      (click),
        .long_press (long_press),
        .repeat_evt (repeat_evt)
    );

    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        o.held  = held;
        o.press = press;
        o.rel   = release_evt;
        o.click = click;
        o.lp    = long_press;
        o.rpt   = repeat_evt;
        return o;
    endfunction

    // Model: long_press when the hold reaches L edges, repeat at L+k*R, click if released
    // no later than the long-press edge.
    always @(posedge clk) begin
        obs_t e;
        e = '0;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                pressed[i] = 1'b0;
                t_since[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!pressed[i]) begin
                    if (buttons_db[i]) begin
                        e.press[i] = 1'b1;
                        pressed[i] = 1'b1;
                        t_since[i] = 0;
                    end
                end else begin
                    t_since[i]++;
                    if (!buttons_db[i]) begin
                        e.rel[i]   = 1'b1;
                        e.click[i] = (t_since[i] <= L);
                        pressed[i] = 1'b0;
                    end else if (t_since[i] == L) begin
                        e.lp[i] = 1'b1;
                    end else if (t_since[i] > L && (t_since[i] - L) % R == 0) begin
                        e.rpt[i] = 1'b1;
                    end
                end
                e.held[i] = pressed[i];
            end
        end
        exp_q.push_back(e);
    end

    // Monitor: compares DUT outputs against the oldest expectation on the falling edge.
    always @(negedge clk) begin
        obs_t a, e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = observe();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs cyc=%0d got held=%h press=%h rel=%h click=%h lp=%h rpt=%h want held=%h press=%h rel=%h click=%h lp=%h rpt=%h",
                         cyc, a.held, a.press, a.rel, a.click, a.lp, a.rpt,
                         e.held, e.press, e.rel, e.click, e.lp, e.rpt);
            end
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Assert reset asynchronously and verify outputs clear without waiting for a clock edge.
    task automatic async_reset_check();
        obs_t a;
        rst_n = 1'b0;
        #1;
        a = observe();
        checks++;
        if (a !== '0) begin
            errors++;
            $display("FAIL async_reset got=%h want=0", a);
        end
    endtask

    initial begin
        // Reset with every button held, then release reset: all five pressed at once.
        buttons_db = 5'h1F;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        buttons_db = '0;
        tick(3);

        // Short click on bit0.
        buttons_db[0] = 1'b1;
        tick(3);
        buttons_db[0] = 1'b0;
        tick(3);

        // Long hold with repeats on bit2.
        buttons_db[2] = 1'b1;
        tick(20);
        buttons_db[2] = 1'b0;
        tick(3);

        // Release exactly at the long-press edge, then exactly at the first repeat edge.
        buttons_db[1] = 1'b1;
        tick(L);
        buttons_db[1] = 1'b0;
        tick(3);
        buttons_db[1] = 1'b1;
        tick(L + R);
        buttons_db[1] = 1'b0;
        tick(3);

        // Simultaneous press of bits 3 and 4, bit4 released early.
        buttons_db[4:3] = 2'b11;
        tick(2);
        buttons_db[4] = 1'b0;
        tick(10);
        buttons_db[3] = 1'b0;
        tick(3);

        // Reset mid-hold, button still down afterwards.
        buttons_db[0] = 1'b1;
        tick(5);
        async_reset_check();
        tick(2);
        rst_n = 1'b1;
        tick(12);
        buttons_db[0] = 1'b0;
        tick(3);

        // Random toggling with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 11) == 0) buttons_db[i] = ~buttons_db[i];
            if ($urandom_range(0, 499) == 0) begin
                async_reset_check();
                tick(1);
                rst_n = 1'b1;
            end
            tick(1);
        end
        buttons_db = '0;
        tick(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
